bus_arbiter: RTL and testbench

- Two-master, single-slave arbiter between the data-side masters and the Bridge.
- Master 0 is the CPU MEM stage. Master 1 is a secondary master (DMA or debug loader).
- Default policy is round-robin. A master may lock the bus for a bounded burst.
- One transaction occupies the Bridge for one cycle; back-to-back transactions are pipelined.

---
 rtl/bus_arbiter.sv | 117 +++++++++++
 tb/tb_bus_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with bounded lock bursts and a two-stage pipeline to the Bridge.
// Optional BUS_ARB_PERF_CNT_EN adds grant and conflict counters.
module bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_lock,
  input  logic              m1_lock,
  input  logic              m0_wen,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_wen,
  output logic [DATA_W-1:0] Bus_wdata,
  input  logic [DATA_W-1:0] Bus_rdata
`ifdef BUS_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       m0_grant_cnt,
  output logic [31:0]       m1_grant_cnt,
  output logic [31:0]       conflict_cnt
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] burst_q, burst_d, run_nx;
  logic last_q, last_d;
  logic locked, win, gnt, win_lock, win_wen, stay;
  logic [ADDR_W-1:0] win_addr, addr_q;
  logic [DATA_W-1:0] win_wdata, wdata_q, m0_rdata_q, m1_rdata_q;
  logic wen_q, v1_q, who1_q, rd1_q, m0_rvalid_q, m1_rvalid_q;
  always_comb begin
    locked    = state_q != IDLE;
    win       = locked ? (state_q == LOCK1) : ((m0_req & m1_req) ? ~last_q : m1_req);
    gnt       = cpu_rst & (win ? m1_req : m0_req);
    win_lock  = win ? m1_lock : m0_lock;
    win_wen   = win ? m1_wen : m0_wen;
    win_addr  = win ? m1_addr : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    m0_gnt    = gnt & ~win;
    m1_gnt    = gnt & win;
    run_nx    = locked ? burst_q + CW'(1) : CW'(1);
    stay      = gnt & win_lock & (run_nx < CW'(MAX_BURST));
    state_d   = stay ? (win ? LOCK1 : LOCK0) : IDLE;
    burst_d   = stay ? run_nx : '0;
    last_d    = gnt ? win : last_q;
  end
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      v1_q        <= 1'b0;
      who1_q      <= 1'b0;
      rd1_q       <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      last_q      <= last_d;
      addr_q      <= gnt ? win_addr : addr_q;
      wdata_q     <= gnt ? win_wdata : wdata_q;
      wen_q       <= gnt & win_wen;
      v1_q        <= gnt;
      who1_q      <= win;
      rd1_q       <= ~win_wen;
      m0_rvalid_q <= v1_q & ~who1_q;
      m1_rvalid_q <= v1_q & who1_q;
      m0_rdata_q  <= (v1_q & rd1_q & ~who1_q) ? Bus_rdata : m0_rdata_q;
      m1_rdata_q  <= (v1_q & rd1_q & who1_q) ? Bus_rdata : m1_rdata_q;
    end
  end
  assign Bus_addr  = addr_q;
  assign Bus_wdata = wdata_q;
  assign Bus_wen   = wen_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
`ifdef BUS_ARB_PERF_CNT_EN
  logic [31:0] m0_gc_q, m1_gc_q, conf_q;
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      m0_gc_q <= '0;
      m1_gc_q <= '0;
      conf_q  <= '0;
    end else begin
      m0_gc_q <= m0_gc_q + 32'(m0_gnt);
      m1_gc_q <= m1_gc_q + 32'(m1_gnt);
      conf_q  <= conf_q + 32'(m0_req & m1_req & ~(m0_gnt & m1_gnt));
    end
  end
  assign m0_grant_cnt = m0_gc_q;
  assign m1_grant_cnt = m1_gc_q;
  assign conflict_cnt = conf_q;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed table vectors, hand sequences and a randomized run against a rule-level model.
module tb_bus_arbiter;
  localparam int MB = 4;
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  logic m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, Bus_rdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, Bus_wen;
  logic [31:0] m0_rdata, m1_rdata, Bus_addr, Bus_wdata;
`ifdef BUS_ARB_PERF_CNT_EN
  logic [31:0] m0_grant_cnt, m1_grant_cnt, conflict_cnt;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct packed {logic r0, r1, l0, l1, g0, g1;} vec_t;
  vec_t ct[6];
  vec_t bt[14];

  always #5 cpu_clk = ~cpu_clk;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_wen(m0_wen), .m1_wen(m1_wen), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata)
`ifdef BUS_ARB_PERF_CNT_EN
    , .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0; m0_wen = 0; m1_wen = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; Bus_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    clr();
    cpu_rst = 0; m0_req = 1; m1_req = 1;
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    @(negedge cpu_clk);
    chk("rst_bus_addr", Bus_addr, 0);
    chk("rst_bus_wen", Bus_wen, 0);
    chk("rst_bus_wdata", Bus_wdata, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    clr();
    cpu_rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic req[2], lock[2], wen[2];
    logic [31:0] addr[2], wdata[2], e_rd[2], e_addr, e_wdata;
    logic e_rv[2], e_wen, p1_v, p1_wen, rst_now;
    int owner, run, last, g, p1_who;
    ct = '{6'b110010, 6'b110001, 6'b110010, 6'b110001, 6'b110010, 6'b110001};
    bt = '{6'b100010, 6'b110101, 6'b110101, 6'b110101, 6'b110101, 6'b110110, 6'b110101,
           6'b110101, 6'b010101, 6'b010101, 6'b010101, 6'b100000, 6'b100010, 6'b110001};
    clr();
    do_reset();
    // m0 read
    m0_req = 1; m0_addr = 32'h0001_0000;
    #1;
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("rd_m1_gnt", m1_gnt, 0);
    @(negedge cpu_clk);
    clr();
    Bus_rdata = 32'hDEAD_BEEF;
    chk("rd_bus_addr", Bus_addr, 32'h0001_0000);
    chk("rd_bus_wen", Bus_wen, 0);
    chk("rd_early_rvalid", m0_rvalid, 0);
    @(negedge cpu_clk);
    Bus_rdata = 0;
    chk("rd_m0_rvalid", m0_rvalid, 1);
    chk("rd_m1_rvalid", m1_rvalid, 0);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    @(negedge cpu_clk);
    chk("rd_rvalid_pulse", m0_rvalid, 0);
    // m1 write
    m1_req = 1; m1_wen = 1; m1_addr = 32'hFFFF_F000; m1_wdata = 32'h1234_5678;
    #1;
    chk("wr_m1_gnt", m1_gnt, 1);
    @(negedge cpu_clk);
    clr();
    Bus_rdata = 32'hCAFE_F00D;
    chk("wr_bus_wen", Bus_wen, 1);
    chk("wr_bus_addr", Bus_addr, 32'hFFFF_F000);
    chk("wr_bus_wdata", Bus_wdata, 32'h1234_5678);
    @(negedge cpu_clk);
    chk("wr_bus_wen_off", Bus_wen, 0);
    chk("wr_bus_addr_hold", Bus_addr, 32'hFFFF_F000);
    chk("wr_m1_rvalid", m1_rvalid, 1);
    chk("wr_m1_rdata_hold", m1_rdata, 0);
    // contention then locked bursts
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {m0_req, m1_req, m0_lock, m1_lock} = {ct[i].r0, ct[i].r1, ct[i].l0, ct[i].l1};
      #1;
      chk($sformatf("ct%0d_gnt", i), {m0_gnt, m1_gnt}, {ct[i].g0, ct[i].g1});
      @(negedge cpu_clk);
    end
`ifdef BUS_ARB_PERF_CNT_EN
    chk("perf_m0", m0_grant_cnt, 3);
    chk("perf_m1", m1_grant_cnt, 3);
    chk("perf_conflict", conflict_cnt, 6);
`endif
    for (int i = 0; i < 14; i++) begin
      {m0_req, m1_req, m0_lock, m1_lock} = {bt[i].r0, bt[i].r1, bt[i].l0, bt[i].l1};
      #1;
      chk($sformatf("bt%0d_gnt", i), {m0_gnt, m1_gnt}, {bt[i].g0, bt[i].g1});
      @(negedge cpu_clk);
    end
    // reset during the bus cycle of an m0 read
    do_reset();
    m0_req = 1; m0_addr = 32'h40;
    #1;
    chk("mr_m0_gnt", m0_gnt, 1);
    @(negedge cpu_clk);
    clr();
    cpu_rst = 0; Bus_rdata = 32'h1111_1111;
    @(negedge cpu_clk);
    chk("mr_no_rvalid", m0_rvalid, 0);
    chk("mr_bus_wen", Bus_wen, 0);
    chk("mr_rdata", m0_rdata, 0);
    cpu_rst = 1; m0_req = 1; m1_req = 1;
    #1;
    chk("mr_tie_gnt", {m0_gnt, m1_gnt}, 2'b10);
    @(negedge cpu_clk);
    clr();
    // randomized run
    do_reset();
    owner = -1; run = 0; last = 1; p1_v = 0; p1_who = 0; p1_wen = 0;
    e_addr = 0; e_wdata = 0; e_wen = 0; e_rv = '{0, 0}; e_rd = '{0, 0};
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge cpu_clk);
      chk("rnd_bus_addr", Bus_addr, e_addr);
      chk("rnd_bus_wdata", Bus_wdata, e_wdata);
      chk("rnd_bus_wen", Bus_wen, e_wen);
      chk("rnd_rvalid", {m0_rvalid, m1_rvalid}, {e_rv[0], e_rv[1]});
      chk("rnd_m0_rdata", m0_rdata, e_rd[0]);
      chk("rnd_m1_rdata", m1_rdata, e_rd[1]);
      for (int m = 0; m < 2; m++) begin
        req[m] = $urandom_range(0, 3) != 0;
        lock[m] = $urandom_range(0, 1) == 1;
        wen[m] = $urandom_range(0, 1) == 1;
        addr[m] = $urandom;
        wdata[m] = $urandom;
      end
      rst_now = $urandom_range(0, 39) == 0;
      cpu_rst = !rst_now;
      Bus_rdata = $urandom;
      {m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen} = {req[0], req[1], lock[0], lock[1], wen[0], wen[1]};
      {m0_addr, m1_addr, m0_wdata, m1_wdata} = {addr[0], addr[1], wdata[0], wdata[1]};
      if (rst_now) g = -1;
      else if (owner >= 0) g = req[owner] ? owner : -1;
      else if (req[0] && req[1]) g = 1 - last;
      else g = req[0] ? 0 : (req[1] ? 1 : -1);
      #1;
      chk("rnd_gnt", {m0_gnt, m1_gnt}, {g == 0, g == 1});
      if (rst_now) begin
        owner = -1; run = 0; last = 1; p1_v = 0;
        e_addr = 0; e_wdata = 0; e_wen = 0; e_rv = '{0, 0}; e_rd = '{0, 0};
      end else begin
        e_rv[0] = p1_v && p1_who == 0;
        e_rv[1] = p1_v && p1_who == 1;
        if (p1_v && !p1_wen) e_rd[p1_who] = Bus_rdata;
        e_wen = g >= 0 && wen[g];
        p1_v = g >= 0;
        if (g < 0) begin
          owner = -1; run = 0;
        end else begin
          e_addr = addr[g]; e_wdata = wdata[g]; p1_who = g; p1_wen = wen[g];
          last = g;
          run = (owner >= 0) ? run + 1 : 1;
          if (lock[g] && run < MB) owner = g;
          else begin
            owner = -1; run = 0;
          end
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
